// File: rtl/if_prefetch_stage.sv
// Fetch stage for the 16-bit MIPS pipeline: owns the PC, reads imem over req/ack,
// and buffers fetched words so ID stalls never lose a fetch.
module if_prefetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ifid_ir,
  output logic [15:0] ifid_pcplus2,
  output logic        ifid_valid,
  output logic [1:0]  buf_count
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(BUF_DEPTH - 1);
  localparam logic [1:0] DEPTH_C = BUF_DEPTH[1:0];

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t state, state_nx;
  logic [15:0] addr, addr_nx;
  logic [15:0] drop_pc, drop_pc_nx;
  logic [1:0] cnt, cnt_nx;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0] qmem [BUF_DEPTH];

  logic [15:0] rpc;
  logic ack_ok, push, bypass, pop, q_push, space;
  logic unused_bit;

  assign unused_bit = redirect_pc[0];
  assign rpc = {redirect_pc[15:1], 1'b0};

  assign imem_req = (state != IDLE);
  assign imem_addr = addr;
  assign buf_count = cnt;

  // ack only counts while a read is actually outstanding
  assign ack_ok = imem_req & imem_ack;
  assign push = (state == WAIT) & ack_ok & ~redirect;
  assign bypass = push & (cnt == 2'd0) & ~stall;
  assign pop = ~redirect & ~stall & (cnt != 2'd0);
  assign q_push = push & ~bypass;

  assign cnt_nx = redirect ? 2'd0
                : cnt + {1'b0, q_push} - {1'b0, pop};
  assign space = (cnt_nx < DEPTH_C);

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_nx = state;
    addr_nx = addr;
    drop_pc_nx = drop_pc;
    if (redirect) begin
      // a read still in flight must finish before addr may move
      if (state != IDLE && !ack_ok) begin
        state_nx = DROP;
        drop_pc_nx = rpc;
      end else begin
        state_nx = WAIT;
        addr_nx = rpc;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (space) state_nx = WAIT;
        end
        WAIT: begin
          if (ack_ok) begin
            addr_nx = addr + 16'd2;
            state_nx = space ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (ack_ok) begin
            addr_nx = drop_pc;
            state_nx = space ? WAIT : IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr <= RESET_PC;
      drop_pc <= RESET_PC;
      cnt <= 2'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      addr <= addr_nx;
      drop_pc <= drop_pc_nx;
      cnt <= cnt_nx;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) rd_ptr <= inc(rd_ptr);
        if (q_push) wr_ptr <= inc(wr_ptr);
      end
    end
  end

  always_ff @(negedge clock) begin
    if (q_push) qmem[wr_ptr] <= {imem_rdata, addr + 16'd2};
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      ifid_ir <= 16'h0000;
      ifid_pcplus2 <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      ifid_ir <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      ifid_ir <= ifid_ir;
    end else if (pop) begin
      ifid_ir <= qmem[rd_ptr][31:16];
      ifid_pcplus2 <= qmem[rd_ptr][15:0];
      ifid_valid <= 1'b1;
    end else if (bypass) begin
      ifid_ir <= imem_rdata;
      ifid_pcplus2 <= addr + 16'd2;
      ifid_valid <= 1'b1;
    end else begin
      ifid_ir <= 16'h0000;
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: queue-based fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_prefetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_ir;
  logic [15:0] ifid_pcplus2;
  logic        ifid_valid;
  logic [1:0]  buf_count;

  logic [15:0] mem [32768];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign imem_rdata = mem[imem_addr[15:1]];

  if_prefetch_stage dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .ifid_ir(ifid_ir),
    .ifid_pcplus2(ifid_pcplus2),
    .ifid_valid(ifid_valid),
    .buf_count(buf_count)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Model: a FIFO of fetched {instr, pc+2}, one outstanding read,
  // and a flag saying whether that read's data is to be thrown away.
  logic [31:0] q [$];
  bit          m_out, m_drop, m_valid;
  logic [15:0] m_addr, m_pend, m_ir, m_pc2;

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_out = 0;
      m_drop = 0;
      m_valid = 0;
      m_addr = 16'h0000;
      m_pend = 16'h0000;
      m_ir = 16'h0000;
      m_pc2 = 16'h0000;
    end else begin : upd
      bit acked, got;
      logic [15:0] d;
      acked = m_out && imem_ack;
      d = mem[m_addr[15:1]];
      if (redirect) begin
        q.delete();
        m_valid = 0;
        m_ir = 16'h0000;
        if (m_out && !acked) begin
          m_drop = 1;
          m_pend = {redirect_pc[15:1], 1'b0};
        end else begin
          m_out = 1;
          m_drop = 0;
          m_addr = {redirect_pc[15:1], 1'b0};
        end
      end else begin
        got = acked && !m_drop;
        if (stall) begin
          if (got) q.push_back({d, m_addr + 16'd2});
        end else if (q.size() > 0) begin
          {m_ir, m_pc2} = q.pop_front();
          m_valid = 1;
          if (got) q.push_back({d, m_addr + 16'd2});
        end else if (got) begin
          m_ir = d;
          m_pc2 = m_addr + 16'd2;
          m_valid = 1;
        end else begin
          m_valid = 0;
          m_ir = 16'h0000;
        end
        if (acked) begin
          m_addr = m_drop ? m_pend : m_addr + 16'd2;
          m_drop = 0;
          m_out = (q.size() < 2);
        end else if (!m_out) begin
          m_out = (q.size() < 2);
        end
      end
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      chk("req", 16'(imem_req), 16'(m_out));
      if (m_out) chk("addr", imem_addr, m_addr);
      chk("valid", 16'(ifid_valid), 16'(m_valid));
      chk("ir", ifid_ir, m_ir);
      if (m_valid) chk("pcplus2", ifid_pcplus2, m_pc2);
      chk("count", 16'(buf_count), 16'(q.size()));
    end
  end

  task automatic nx();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 16'(imem_req), 16'h0);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
    chk({tag, "_ir"}, ifid_ir, 16'h0000);
    chk({tag, "_pc2"}, ifid_pcplus2, 16'h0000);
    chk({tag, "_valid"}, 16'(ifid_valid), 16'h0);
    chk({tag, "_count"}, 16'(buf_count), 16'h0);
  endtask

  task automatic do_reset();
    reset = 1;
    stall = 0;
    redirect = 0;
    redirect_pc = 16'h0000;
    imem_ack = 0;
    nx();
    nx();
    chk_reset_vals("rst");
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 7) ^ 16'hA5C3;
    mem[0] = 16'h4103;
    mem[1] = 16'h4207;
    mem[2] = 16'h0000;
    mem[3] = 16'h1111;
    mem[4] = 16'h2222;
    mem[16] = 16'h3A10;
    mem[32767] = 16'h7E7E;

    // streaming with ack tied high
    do_reset();
    imem_ack = 1;
    nx();
    chk("t1_e1_req", 16'(imem_req), 16'h1);
    chk("t1_e1_addr", imem_addr, 16'h0000);
    nx();
    chk("t1_e2_ir", ifid_ir, 16'h4103);
    chk("t1_e2_pc2", ifid_pcplus2, 16'h0002);
    nx();
    chk("t1_e3_ir", ifid_ir, 16'h4207);
    chk("t1_e3_pc2", ifid_pcplus2, 16'h0004);
    nx();
    chk("t1_e4_ir", ifid_ir, 16'h0000);
    chk("t1_e4_pc2", ifid_pcplus2, 16'h0006);
    chk("t1_e4_valid", 16'(ifid_valid), 16'h1);

    // stall fills the queue, then drains in order
    do_reset();
    imem_ack = 1;
    repeat (3) nx();
    stall = 1;
    repeat (4) nx();
    chk("t2_hold_ir", ifid_ir, 16'h4207);
    chk("t2_full", 16'(buf_count), 16'h2);
    chk("t2_req_low", 16'(imem_req), 16'h0);
    stall = 0;
    nx();
    chk("t2_w2", ifid_ir, 16'h0000);
    chk("t2_w2_pc2", ifid_pcplus2, 16'h0006);
    nx();
    chk("t2_w3", ifid_ir, 16'h1111);
    nx();
    chk("t2_w4", ifid_ir, 16'h2222);
    chk("t2_w4_pc2", ifid_pcplus2, 16'h000A);

    // memory wait states
    do_reset();
    imem_ack = 1;
    repeat (3) nx();
    imem_ack = 0;
    repeat (2) begin
      nx();
      chk("t3_req", 16'(imem_req), 16'h1);
      chk("t3_addr", imem_addr, 16'h0004);
      chk("t3_bubble_v", 16'(ifid_valid), 16'h0);
      chk("t3_bubble_ir", ifid_ir, 16'h0000);
    end
    imem_ack = 1;
    nx();
    chk("t3_valid", 16'(ifid_valid), 16'h1);
    chk("t3_ir", ifid_ir, 16'h0000);
    chk("t3_pc2", ifid_pcplus2, 16'h0006);

    // redirect while a read is pending
    do_reset();
    imem_ack = 1;
    repeat (4) nx();
    imem_ack = 0;
    redirect = 1;
    redirect_pc = 16'h0021;
    nx();
    chk("t4_flush_v", 16'(ifid_valid), 16'h0);
    chk("t4_flush_cnt", 16'(buf_count), 16'h0);
    chk("t4_hold_addr", imem_addr, 16'h0006);
    redirect = 0;
    nx();
    imem_ack = 1;
    begin : t4_wait
      bit seen;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
        nx();
        seen = ifid_valid;
      end
      chk("t4_seen", 16'(seen), 16'h1);
      chk("t4_ir", ifid_ir, 16'h3A10);
      chk("t4_pc2", ifid_pcplus2, 16'h0022);
    end

    // wrap at top of address space
    do_reset();
    imem_ack = 1;
    repeat (3) nx();
    redirect = 1;
    redirect_pc = 16'hFFFE;
    nx();
    chk("t5_addr", imem_addr, 16'hFFFE);
    redirect = 0;
    nx();
    chk("t5_ir0", ifid_ir, 16'h7E7E);
    chk("t5_pc0", ifid_pcplus2, 16'h0000);
    nx();
    chk("t5_ir1", ifid_ir, 16'h4103);
    chk("t5_pc1", ifid_pcplus2, 16'h0002);

    // async reset between edges, then a stale ack
    do_reset();
    imem_ack = 1;
    repeat (3) nx();
    imem_ack = 0;
    nx();
    chk("t6_pending", 16'(imem_req), 16'h1);
    #2;
    reset = 1;
    #1;
    chk_reset_vals("t6");
    imem_ack = 1;
    nx();
    reset = 0;
    nx();
    chk("t6_no_late", 16'(ifid_valid), 16'h0);
    chk("t6_req", 16'(imem_req), 16'h1);
    nx();
    chk("t6_first", ifid_ir, 16'h4103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
